// File: rtl/lr_pick_ctrl.sv
// lr_pick_ctrl
//   Frame-rate controller for the left/right pick sprite mover. It turns the
//   two HID keycode slots into a 3-bit direction code and a pick-mode enable.
//   A short tap moves the pick slowly. A sustained hold promotes it to fast
//   motion. The mode key toggles pick mode, and a cooldown debounces it.
//
//   Optional build macro: LRPICK_AUTOEXIT_EN
//     When defined, pick mode clears by itself after IDLE_FRAMES consecutive
//     frames without the move key.
//
// Ports
//   frame_clk  in   1  frame clock; all state updates on its rising edge
//   Reset      in   1  synchronous active-high reset
//   keycode0   in   8  first HID keycode slot (8'h00 = none)
//   keycode1   in   8  second HID keycode slot (8'h00 = none)
//   LRdir      out  3  3'b000 stop, 3'b001 slow move, 3'b010 fast move
//   pickMode   out  1  1 = pick active, 0 = pick parked
//
// FSM states
//   state   | meaning
//   IDLE    | no motion; move key released or pick mode off
//   SLOW    | move key held for fewer than HOLD_FRAMES frames
//   FAST    | move key held for at least HOLD_FRAMES frames

module lr_pick_ctrl #(
    parameter logic [7:0]  KEY_MOVE      = 8'h50,
    parameter logic [7:0]  KEY_MODE      = 8'h2C,
    parameter int unsigned HOLD_FRAMES   = 30,
    parameter int unsigned MODE_COOLDOWN = 15,
    parameter int unsigned IDLE_FRAMES   = 240
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [2:0] LRdir,
    output logic       pickMode
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] COOL_LOAD = 8'(MODE_COOLDOWN);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] cool_q, cool_d;
    logic       mode_prev_q, mode_prev_d;
    logic       pick_q, pick_d;
    logic [2:0] lrdir_q, lrdir_d;

    logic move_key;
    logic mode_key;
    logic toggle;
    logic auto_exit;

`ifdef LRPICK_AUTOEXIT_EN
    localparam logic [9:0] IDLE_LAST = 10'(IDLE_FRAMES - 1);
    logic [9:0] idle_q, idle_d;
`endif

    always_comb begin
        move_key    = (keycode0 == KEY_MOVE) | (keycode1 == KEY_MOVE);
        mode_key    = (keycode0 == KEY_MODE) | (keycode1 == KEY_MODE);
        mode_prev_d = mode_key;
        toggle      = mode_key & ~mode_prev_q & (cool_q == 8'd0);
        auto_exit   = 1'b0;

`ifdef LRPICK_AUTOEXIT_EN
        // A user toggle in the same frame takes precedence over auto-exit.
        auto_exit = pick_q & ~move_key & (idle_q == IDLE_LAST) & ~toggle;
        if (~pick_q | move_key | (idle_q == IDLE_LAST)) begin
            idle_d = 10'd0;
        end else begin
            idle_d = idle_q + 10'd1;
        end
`endif

        if (toggle) begin
            pick_d = ~pick_q;
        end else if (auto_exit) begin
            pick_d = 1'b0;
        end else begin
            pick_d = pick_q;
        end

        if (toggle | auto_exit) begin
            cool_d = COOL_LOAD;
        end else if (cool_q != 8'd0) begin
            cool_d = cool_q - 8'd1;
        end else begin
            cool_d = cool_q;
        end
    end

    // A pick mode that is off, or is turning off in this frame, forces IDLE.
    // A pick mode that is turning on this frame still sees pick_q = 0, so the
    // move key first takes effect on the following frame.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;

        if (~pick_q | ~pick_d) begin
            state_d = ST_IDLE;
            hold_d  = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (move_key) begin
                        state_d = ST_SLOW;
                        hold_d  = 8'd1;
                    end
                end
                ST_SLOW: begin
                    if (!move_key) begin
                        state_d = ST_IDLE;
                        hold_d  = 8'd0;
                    end else begin
                        // >= so that HOLD_FRAMES = 1 still spends one frame in SLOW.
                        if (hold_q >= HOLD_LAST) begin
                            state_d = ST_FAST;
                        end
                        if (hold_q != 8'hFF) begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                end
                ST_FAST: begin
                    if (!move_key) begin
                        state_d = ST_IDLE;
                        hold_d  = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = 8'd0;
                end
            endcase
        end

        unique case (state_d)
            ST_SLOW: lrdir_d = 3'b001;
            ST_FAST: lrdir_d = 3'b010;
            default: lrdir_d = 3'b000;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'd0;
            cool_q      <= 8'd0;
            mode_prev_q <= 1'b0;
            pick_q      <= 1'b0;
            lrdir_q     <= 3'b000;
`ifdef LRPICK_AUTOEXIT_EN
            idle_q      <= 10'd0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cool_q      <= cool_d;
            mode_prev_q <= mode_prev_d;
            pick_q      <= pick_d;
            lrdir_q     <= lrdir_d;
`ifdef LRPICK_AUTOEXIT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    assign LRdir    = lrdir_q;
    assign pickMode = pick_q;

endmodule

// File: tb/tb_lr_pick_ctrl.sv
// Testbench for lr_pick_ctrl. Directed scenarios follow the frame-level
// behaviour of the pick controller. A randomized run compares the DUT against a
// reference model that tracks how many consecutive frames the move key has
// been held while pick mode is on.

module tb_lr_pick_ctrl;

    localparam logic [7:0] K_MOVE = 8'h50;
    localparam logic [7:0] K_MODE = 8'h2C;
    localparam int HOLD_FRAMES   = 30;
    localparam int MODE_COOLDOWN = 15;
    localparam int IDLE_FRAMES   = 240;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode0  = 8'h00;
    logic [7:0] keycode1  = 8'h00;
    logic [2:0] LRdir;
    logic       pickMode;

    int checks = 0;
    int passes = 0;

    // reference model state
    bit m_pick = 0;
    bit m_prev = 0;
    int m_cd   = 0;
    int m_run  = 0;
    int m_idle = 0;
    logic [2:0] m_dir = 3'b000;

    lr_pick_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode0  (keycode0),
        .keycode1  (keycode1),
        .LRdir     (LRdir),
        .pickMode  (pickMode)
    );

    always #5 frame_clk = ~frame_clk;

    // Drive one frame of inputs, advance one edge, update the model, then
    // settle 1 time unit past the edge so the outputs can be sampled.
    task automatic step(input logic [7:0] k0, input logic [7:0] k1, input bit rst);
        bit mv, md, tog, ex, new_pick;
        int slow_limit;
        keycode0 = k0;
        keycode1 = k1;
        Reset    = rst;
        @(posedge frame_clk);
        if (rst) begin
            m_pick = 0; m_prev = 0; m_cd = 0; m_run = 0; m_idle = 0;
        end else begin
            mv  = (k0 == K_MOVE) || (k1 == K_MOVE);
            md  = (k0 == K_MODE) || (k1 == K_MODE);
            tog = md && !m_prev && (m_cd == 0);
            m_prev = md;
            ex = 0;
`ifdef LRPICK_AUTOEXIT_EN
            ex = m_pick && !mv && (m_idle == IDLE_FRAMES - 1) && !tog;
            if (!m_pick || mv || m_idle == IDLE_FRAMES - 1) m_idle = 0;
            else m_idle = m_idle + 1;
`endif
            new_pick = tog ? !m_pick : (ex ? 1'b0 : m_pick);
            if (tog || ex) m_cd = MODE_COOLDOWN;
            else if (m_cd > 0) m_cd = m_cd - 1;
            if (!m_pick || !new_pick || !mv) m_run = 0;
            else if (m_run < 100000) m_run = m_run + 1;
            m_pick = new_pick;
        end
        // first held frame is always slow; fast once held HOLD_FRAMES frames
        slow_limit = (HOLD_FRAMES < 2) ? 2 : HOLD_FRAMES;
        if (m_run == 0) m_dir = 3'b000;
        else if (m_run < slow_limit) m_dir = 3'b001;
        else m_dir = 3'b010;
        #1;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(K_MOVE, 8'h00, 1'b1);
            checks++;
            if (LRdir !== 3'b000 || pickMode !== 1'b0)
                $display("FAIL reset_hold[%0d] got LRdir=%b pickMode=%b exp 000/0", i, LRdir, pickMode);
            else passes++;
        end
        for (int i = 0; i < 3; i++) begin
            step(K_MOVE, 8'h00, 1'b0);
            checks++;
            if (LRdir !== 3'b000 || pickMode !== 1'b0)
                $display("FAIL reset_release[%0d] got LRdir=%b pickMode=%b exp 000/0", i, LRdir, pickMode);
            else passes++;
        end
        idle_frames(1);
    endtask

    task automatic test_mode_toggle();
        logic exp_pick;
        for (int f = 0; f <= 20; f++) begin
            if (f == 0 || f == 5 || f == 20) step(K_MODE, 8'h00, 1'b0);
            else step(8'h00, 8'h00, 1'b0);
            exp_pick = (f < 20) ? 1'b1 : 1'b0;
            if (f == 0 || f == 4 || f == 5 || f == 19 || f == 20) begin
                checks++;
                if (pickMode !== exp_pick)
                    $display("FAIL mode_toggle frame %0d got pickMode=%b exp %b", f, pickMode, exp_pick);
                else passes++;
            end
        end
        idle_frames(MODE_COOLDOWN + 1);
    endtask

    task automatic test_hold();
        logic [2:0] exp_dir;
        step(K_MODE, 8'h00, 1'b0);
        checks++;
        if (pickMode !== 1'b1) $display("FAIL hold_enter got pickMode=%b exp 1", pickMode);
        else passes++;
        for (int f = 1; f <= 40; f++) begin
            step(8'h00, K_MOVE, 1'b0);
            exp_dir = (f < 30) ? 3'b001 : 3'b010;
            if (f == 1 || f == 29 || f == 30 || f == 40) begin
                checks++;
                if (LRdir !== exp_dir)
                    $display("FAIL hold frame %0d got LRdir=%b exp %b", f, LRdir, exp_dir);
                else passes++;
            end
        end
        step(8'h00, 8'h00, 1'b0);
        checks++;
        if (LRdir !== 3'b000) $display("FAIL hold_release got LRdir=%b exp 000", LRdir);
        else passes++;
    endtask

    task automatic test_tap();
        for (int f = 0; f < 3; f++) begin
            step(K_MOVE, 8'h00, 1'b0);
            checks++;
            if (LRdir !== 3'b001) $display("FAIL tap frame %0d got LRdir=%b exp 001", f, LRdir);
            else passes++;
        end
        step(8'h00, 8'h00, 1'b0);
        checks++;
        if (LRdir !== 3'b000) $display("FAIL tap_release got LRdir=%b exp 000", LRdir);
        else passes++;
        step(K_MOVE, K_MOVE, 1'b0);
        checks++;
        if (LRdir !== 3'b001) $display("FAIL tap_restart got LRdir=%b exp 001", LRdir);
        else passes++;
        step(8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_toggle_off_in_fast();
        for (int f = 1; f <= 30; f++) step(K_MOVE, 8'h00, 1'b0);
        checks++;
        if (LRdir !== 3'b010) $display("FAIL fast_reach got LRdir=%b exp 010", LRdir);
        else passes++;
        step(K_MOVE, K_MODE, 1'b0);
        checks++;
        if (LRdir !== 3'b000 || pickMode !== 1'b0)
            $display("FAIL toggle_off_fast got LRdir=%b pickMode=%b exp 000/0", LRdir, pickMode);
        else passes++;
        step(K_MOVE, 8'h00, 1'b0);
        checks++;
        if (LRdir !== 3'b000) $display("FAIL parked_move got LRdir=%b exp 000", LRdir);
        else passes++;
        idle_frames(MODE_COOLDOWN + 1);
    endtask

    task automatic test_reset_mid_hold();
        step(K_MODE, 8'h00, 1'b0);
        for (int f = 1; f <= 35; f++) step(K_MOVE, 8'h00, 1'b0);
        checks++;
        if (LRdir !== 3'b010) $display("FAIL mid_hold_fast got LRdir=%b exp 010", LRdir);
        else passes++;
        step(K_MOVE, 8'h00, 1'b1);
        checks++;
        if (LRdir !== 3'b000 || pickMode !== 1'b0)
            $display("FAIL mid_hold_reset got LRdir=%b pickMode=%b exp 000/0", LRdir, pickMode);
        else passes++;
        step(K_MOVE, 8'h00, 1'b0);
        checks++;
        if (LRdir !== 3'b000) $display("FAIL post_reset got LRdir=%b exp 000", LRdir);
        else passes++;
        // cooldown was cleared by reset, so an immediate toggle is accepted
        step(K_MODE, 8'h00, 1'b0);
        checks++;
        if (pickMode !== 1'b1) $display("FAIL post_reset_toggle got pickMode=%b exp 1", pickMode);
        else passes++;
        idle_frames(MODE_COOLDOWN + 1);
    endtask

`ifdef LRPICK_AUTOEXIT_EN
    task automatic test_autoexit();
        if (pickMode !== 1'b1) step(K_MODE, 8'h00, 1'b0);
        else begin
            step(K_MODE, 8'h00, 1'b0);
            idle_frames(MODE_COOLDOWN + 1);
            step(K_MODE, 8'h00, 1'b0);
        end
        idle_frames(IDLE_FRAMES - 1);
        checks++;
        if (pickMode !== 1'b1) $display("FAIL autoexit_early got pickMode=%b exp 1", pickMode);
        else passes++;
        idle_frames(1);
        checks++;
        if (pickMode !== 1'b0) $display("FAIL autoexit_drop got pickMode=%b exp 0", pickMode);
        else passes++;
        idle_frames(MODE_COOLDOWN + 1);
        step(K_MODE, 8'h00, 1'b0);
        idle_frames(IDLE_FRAMES - 2);
        step(K_MOVE, 8'h00, 1'b0);
        idle_frames(IDLE_FRAMES - 1);
        checks++;
        if (pickMode !== 1'b1) $display("FAIL autoexit_restart got pickMode=%b exp 1", pickMode);
        else passes++;
        idle_frames(1);
        checks++;
        if (pickMode !== 1'b0) $display("FAIL autoexit_second got pickMode=%b exp 0", pickMode);
        else passes++;
        idle_frames(MODE_COOLDOWN + 1);
    endtask
`endif

    task automatic test_random();
        logic [7:0] fill_tab [3];
        logic [7:0] a, b, t;
        bit mv_on, md, rs;
        int errs;
        fill_tab[0] = 8'h00; fill_tab[1] = 8'h04; fill_tab[2] = 8'h1A;
        mv_on = 0;
        errs  = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) mv_on = !mv_on;
            md = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 799) == 0);
            a = mv_on ? K_MOVE : fill_tab[$urandom_range(0, 2)];
            b = fill_tab[$urandom_range(0, 2)];
            if (mv_on && $urandom_range(0, 9) == 0) b = K_MOVE;
            if (md) b = K_MODE;
            if ($urandom_range(0, 1) == 1) begin
                t = a; a = b; b = t;
            end
            step(a, b, rs);
            checks++;
            if (LRdir !== m_dir || pickMode !== m_pick) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d got LRdir=%b pickMode=%b exp %b/%b",
                             i, LRdir, pickMode, m_dir, m_pick);
            end else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_mode_toggle();
        test_hold();
        test_tap();
        test_toggle_off_in_fast();
        test_reset_mid_hold();
`ifdef LRPICK_AUTOEXIT_EN
        test_autoexit();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lr_pick_ctrl.md
Name: lr_pick_ctrl

Overview:
Frame-rate controller that turns keyboard keycodes into the 3-bit LRdir direction code and the pickMode enable consumed by the left/right pick sprite mover. It sits between the USB keyboard keycode registers and the pick motion block. It runs on the same frame_clk so that it produces one direction decision per frame. Its state machine implements tap = slow move and hold = fast move, plus a debounced toggle for pick mode.

Parameters:
KEY_MOVE, 8'h50, HID keycode that drives the pick (left arrow)
KEY_MODE, 8'h2C, HID keycode that toggles pickMode (space)
HOLD_FRAMES, 30, consecutive frames KEY_MOVE must be held before SLOW promotes to FAST (1..255)
MODE_COOLDOWN, 15, frames after a mode toggle during which further toggles are ignored (0..255)
IDLE_FRAMES, 240, frames of no KEY_MOVE in pick mode before auto-exit (used only with the optional feature; 1..1023)

Ports:
frame_clk  input  1  frame clock; all state updates on its rising edge
Reset  input  1  synchronous, active-high reset, sampled on posedge frame_clk
keycode0  input  8  first reported HID keycode (8'h00 = none)
keycode1  input  8  second reported HID keycode (8'h00 = none)
LRdir  output  3  direction code: 3'b000 stop, 3'b001 slow move, 3'b010 fast move; no other values are ever driven
pickMode  output  1  1 = pick active, 0 = pick parked

Behaviour:
- Single clock (frame_clk). Reset is synchronous and active-high.
- Reset values: LRdir = 3'b000, pickMode = 0, FSM = IDLE, hold_cnt = 0, cool_cnt = 0, mode_prev = 0.
- Key decode is combinational: move_key = (keycode0 == KEY_MOVE) | (keycode1 == KEY_MOVE). mode_key is decoded the same way from KEY_MODE.
- All outputs are registered. LRdir reflects the key state sampled on the same edge, so latency is 1 frame_clk.
- Mode toggle:
  - Rising-edge detect: mode_key & ~mode_prev. mode_prev is updated every cycle.
  - An edge with cool_cnt == 0 toggles pickMode and loads cool_cnt = MODE_COOLDOWN.
  - cool_cnt decrements each cycle while nonzero. An edge while cool_cnt != 0 is ignored.
  - Holding mode_key never re-toggles.
- FSM states IDLE, SLOW, FAST, evaluated each cycle:
  - Priority 1: if pickMode (the registered value, or the value being cleared this cycle) is 0, go to IDLE and clear hold_cnt.
  - IDLE: move_key goes to SLOW with hold_cnt = 1; otherwise stay.
  - SLOW: ~move_key goes to IDLE with hold_cnt = 0. If move_key and hold_cnt == HOLD_FRAMES-1, go to FAST. Otherwise hold_cnt += 1.
  - FAST: ~move_key goes to IDLE with hold_cnt = 0; otherwise stay. hold_cnt saturates and does not wrap.
- LRdir encoding by state: IDLE → 000, SLOW → 001, FAST → 010.
- Simultaneous events:
  - A toggle that turns pickMode off forces IDLE in that same cycle, so the next LRdir is 000.
  - A toggle that turns pickMode on does not act on move_key until the next cycle.
  - Both keycodes equal to KEY_MOVE counts as a single press.
- Reset mid-hold: all counters clear. FAST is left immediately and LRdir = 000 on the next edge.
- HOLD_FRAMES = 1 goes IDLE → SLOW → FAST on consecutive frames.
- Widths: hold_cnt and cool_cnt are 8-bit unsigned; the idle counter is 10-bit. There is no signed arithmetic.

Optional Feature:
LRPICK_AUTOEXIT_EN:
- Defined: a 10-bit idle_cnt counts frames with pickMode = 1 and ~move_key, and resets to 0 on move_key or when pickMode = 0. When idle_cnt reaches IDLE_FRAMES-1, pickMode clears next edge, idle_cnt clears, and cool_cnt loads MODE_COOLDOWN.
- If a user toggle occurs in the same cycle, the toggle wins and auto-exit is suppressed.
- Undefined: no idle_cnt; pickMode changes only by key toggle or Reset.

Test Plan:
1. Reset high 2 cycles with keycode0 = 8'h50 → LRdir = 000, pickMode = 0 throughout; after release, still 000 because pickMode = 0.
2. Space pressed 1 frame → pickMode = 1 on the next edge. Space re-pressed 5 frames later → ignored (cooldown 15). Re-pressed at frame 20 → pickMode = 0.
3. pickMode = 1, hold 8'h50 on keycode1 for 40 frames → LRdir = 001 for frames 1–29, 010 from frame 30 to 40. Release → 000 next edge.
4. pickMode = 1, tap 8'h50 for 3 frames → 001, 001, 001, then 000. Hold again → restarts in slow (001), confirming hold_cnt cleared.
5. In FAST, press space (cooldown expired) → pickMode = 0 and LRdir = 000 on the same next edge, with 8'h50 still held.
6. (LRPICK_AUTOEXIT_EN, IDLE_FRAMES = 240) pickMode = 1, no keys → pickMode drops after 240 frames. With 8'h50 pressed at frame 239 → pickMode stays 1 and the count restarts.
